// File: rtl/xadc_drp_responder.sv
// DRP slave emulating the XADC aux-channel sequencer (channels 6, 7, 14, 15) for joystick reads.
// Round-robin slot sampling plus a fixed-latency DRP read/write responder with sticky protocol error.
module xadc_drp_responder #(
  parameter int CONV_CYCLES  = 26,
  parameter int DRDY_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  daddr_in,
  input  logic        den_in,
  input  logic        dwe_in,
  input  logic [15:0] di_in,
  output logic [15:0] do_out,
  output logic        drdy_out,
  output logic        busy_out,
  output logic        eoc_out,
  output logic [4:0]  channel_out,
  input  logic [11:0] sample_aux6,
  input  logic [11:0] sample_aux7,
  input  logic [11:0] sample_aux14,
  input  logic [11:0] sample_aux15,
  output logic        protocol_err_out
);

  localparam int             CW        = $clog2(CONV_CYCLES);
  localparam logic [CW-1:0]  SLOT_LAST = CW'(CONV_CYCLES - 1);
  localparam logic [3:0]     WAIT_INIT = 4'(DRDY_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } drp_state_t;

  logic [CW-1:0] slot_cnt;
  logic [1:0]    ptr;
  logic [11:0]   result [4];
  logic [15:0]   cfg    [3];
  logic [11:0]   cur_sample;
  logic [15:0]   rd_val;

  drp_state_t    state;
  logic [3:0]    wait_cnt;
  logic [6:0]    cap_addr;
  logic          cap_we;
  logic [15:0]   cap_di;
  logic [15:0]   cap_rd;

  // Pointer 0..3 maps to aux 6, 7, 14, 15.
  function automatic logic [4:0] chan_addr(input logic [1:0] p);
    return {1'b1, p[1], 2'b11, p[0]};
  endfunction

  always_comb begin
    cur_sample = sample_aux6;
    case (ptr)
      2'd0: cur_sample = sample_aux6;
      2'd1: cur_sample = sample_aux7;
      2'd2: cur_sample = sample_aux14;
      2'd3: cur_sample = sample_aux15;
      default: cur_sample = sample_aux6;
    endcase
  end

  // Decoded from the live registers so a read on a slot-end edge sees the old result.
  always_comb begin
    rd_val = 16'h0000;
    case (daddr_in)
      7'h16: rd_val = {result[0], 4'h0};
      7'h17: rd_val = {result[1], 4'h0};
      7'h1E: rd_val = {result[2], 4'h0};
      7'h1F: rd_val = {result[3], 4'h0};
      7'h40: rd_val = cfg[0];
      7'h41: rd_val = cfg[1];
      7'h42: rd_val = cfg[2];
      default: rd_val = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt    <= '0;
      ptr         <= 2'd0;
      eoc_out     <= 1'b0;
      busy_out    <= 1'b0;
      channel_out <= 5'd0;
      for (int i = 0; i < 4; i++) result[i] <= 12'h000;
    end else begin
      eoc_out  <= 1'b0;
      busy_out <= 1'b1;
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt    <= '0;
        result[ptr] <= cur_sample;
        eoc_out     <= 1'b1;
        busy_out    <= 1'b0;
        channel_out <= chan_addr(ptr);
        ptr         <= ptr + 2'd1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      wait_cnt         <= 4'd0;
      cap_addr         <= 7'd0;
      cap_we           <= 1'b0;
      cap_di           <= 16'h0000;
      cap_rd           <= 16'h0000;
      do_out           <= 16'h0000;
      drdy_out         <= 1'b0;
      protocol_err_out <= 1'b0;
      for (int i = 0; i < 3; i++) cfg[i] <= 16'h0000;
    end else begin
      drdy_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (den_in) begin
            cap_addr <= daddr_in;
            cap_we   <= dwe_in;
            cap_di   <= di_in;
            cap_rd   <= rd_val;
            if (DRDY_LATENCY == 1) begin
              // Single-cycle latency completes straight from the capture data.
              state    <= ST_RESP;
              drdy_out <= 1'b1;
              if (dwe_in) begin
                if (daddr_in == 7'h40 || daddr_in == 7'h41 || daddr_in == 7'h42)
                  cfg[daddr_in[1:0]] <= di_in;
              end else begin
                do_out <= rd_val;
              end
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (den_in) protocol_err_out <= 1'b1;
          if (wait_cnt == 4'd1) begin
            state    <= ST_RESP;
            drdy_out <= 1'b1;
            if (cap_we) begin
              if (cap_addr == 7'h40 || cap_addr == 7'h41 || cap_addr == 7'h42)
                cfg[cap_addr[1:0]] <= cap_di;
            end else begin
              do_out <= cap_rd;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (den_in) protocol_err_out <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Directed bench: reset state, slot sequencing, table-driven DRP vectors and multi-cycle corner cases.
module tb_xadc_drp_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  daddr = 7'd0;
  logic        den0 = 1'b0, den1 = 1'b0;
  logic        dwe = 1'b0;
  logic [15:0] di = 16'h0000;
  logic [11:0] s6 = 12'hABC, s7 = 12'h111, s14 = 12'hDEF, s15 = 12'hF0F;

  logic [15:0] do0, do1;
  logic        drdy0, drdy1, busy0, busy1, eoc0, eoc1, err0, err1;
  logic [4:0]  ch0, ch1;

  int tests = 0;
  int fails = 0;
  int cyc;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  xadc_drp_responder dut0 (
    .clk(clk), .rst_n(rst_n), .daddr_in(daddr), .den_in(den0), .dwe_in(dwe), .di_in(di),
    .do_out(do0), .drdy_out(drdy0), .busy_out(busy0), .eoc_out(eoc0), .channel_out(ch0),
    .sample_aux6(s6), .sample_aux7(s7), .sample_aux14(s14), .sample_aux15(s15),
    .protocol_err_out(err0)
  );

  xadc_drp_responder #(.CONV_CYCLES(26), .DRDY_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .daddr_in(daddr), .den_in(den1), .dwe_in(dwe), .di_in(di),
    .do_out(do1), .drdy_out(drdy1), .busy_out(busy1), .eoc_out(eoc1), .channel_out(ch1),
    .sample_aux6(s6), .sample_aux7(s7), .sample_aux14(s14), .sample_aux15(s15),
    .protocol_err_out(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Starts and ends on a negedge. Checks latency, read data and single-cycle drdy.
  task automatic drp(input bit sel, input bit we, input logic [6:0] a, input logic [15:0] d,
                     input int exp_lat, input logic [15:0] exp_do, input string name);
    int k;
    bit seen;
    daddr = a; dwe = we; di = d;
    if (sel) den1 = 1'b1; else den0 = 1'b1;
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      den0 = 1'b0; den1 = 1'b0;
      k++;
      if (sel ? drdy1 : drdy0) seen = 1'b1;
    end
    chk({name, " latency"}, seen ? k : 99, exp_lat);
    chk({name, " do"}, sel ? do1 : do0, exp_do);
    @(negedge clk);
    chk({name, " drdy width"}, sel ? drdy1 : drdy0, 1'b0);
  endtask

  typedef struct {
    bit          we;
    logic [6:0]  addr;
    logic [15:0] wdat;
    logic [15:0] exp_do;
    string       name;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int k, n, pulses;
    logic [4:0] seq [4];
    seq[0] = 5'h16; seq[1] = 5'h17; seq[2] = 5'h1E; seq[3] = 5'h1F;

    vecs[0]  = '{1'b1, 7'h41, 16'h1234, 16'hABC0, "wr41"};
    vecs[1]  = '{1'b0, 7'h41, 16'h0000, 16'h1234, "rd41"};
    vecs[2]  = '{1'b0, 7'h05, 16'h0000, 16'h0000, "rd05"};
    vecs[3]  = '{1'b1, 7'h16, 16'hFFFF, 16'h0000, "wr16"};
    vecs[4]  = '{1'b0, 7'h16, 16'h0000, 16'hABC0, "rd16"};
    vecs[5]  = '{1'b1, 7'h40, 16'h00AA, 16'hABC0, "wr40"};
    vecs[6]  = '{1'b0, 7'h40, 16'h0000, 16'h00AA, "rd40"};
    vecs[7]  = '{1'b0, 7'h42, 16'h0000, 16'h0000, "rd42"};
    vecs[8]  = '{1'b1, 7'h43, 16'h5555, 16'h0000, "wr43"};
    vecs[9]  = '{1'b0, 7'h43, 16'h0000, 16'h0000, "rd43"};
    vecs[10] = '{1'b0, 7'h1E, 16'h0000, 16'hDEF0, "rd1E"};
    vecs[11] = '{1'b0, 7'h1F, 16'h0000, 16'hF0F0, "rd1F"};

    // Reset state
    #23;
    chk("rst do", do0, 16'h0000);
    chk("rst drdy", drdy0, 1'b0);
    chk("rst busy", busy0, 1'b0);
    chk("rst eoc", eoc0, 1'b0);
    chk("rst channel", ch0, 5'h00);
    chk("rst err", err0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // First conversion lands 26 cycles after release
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) chk("busy after release", busy0, 1'b1);
    end while (!eoc0 && k < 100);
    chk("first eoc cycle", k, 26);
    chk("first channel", ch0, 5'h16);
    chk("busy low on eoc", busy0, 1'b0);
    drp(1'b0, 1'b0, 7'h16, 16'h0000, 4, 16'hABC0, "first rd16");

    // Free-run eight slots
    for (int i = 0; i < 8 * 26; i++) begin
      @(negedge clk);
      chk("eoc pattern", eoc0, (cyc % 26) == 0);
      chk("busy pattern", busy0, (cyc % 26) != 0);
      if ((cyc % 26) == 0) chk("channel seq", ch0, seq[((cyc / 26) - 1) % 4]);
    end

    foreach (vecs[i])
      drp(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdat, 4, vecs[i].exp_do, vecs[i].name);
    drp(1'b0, 1'b0, 7'h17, 16'h0000, 4, 16'h1110, "rd17 old");

    // Read 0x17 on the very edge that converts the new aux7 sample
    n = cyc / 26 + 2;
    while (n % 4 != 2) n++;
    k = 0;
    while (cyc != 26 * n - 1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("align to slot end", cyc, 26 * n - 1);
    s7 = 12'h222;
    drp(1'b0, 1'b0, 7'h17, 16'h0000, 4, 16'h1110, "rd17 collide");
    drp(1'b0, 1'b0, 7'h17, 16'h0000, 4, 16'h2220, "rd17 new");

    // Second den while outstanding: one drdy, sticky error
    daddr = 7'h16; dwe = 1'b0;
    den0 = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      den0 = (i == 1);
      if (drdy0) pulses++;
    end
    chk("double den drdy count", pulses, 1);
    chk("protocol err set", err0, 1'b1);
    chk("other dut err clear", err1, 1'b0);
    drp(1'b0, 1'b0, 7'h1F, 16'h0000, 4, 16'hF0F0, "rd1F after err");
    chk("protocol err sticky", err0, 1'b1);

    // Asynchronous reset while in WAIT
    daddr = 7'h16; dwe = 1'b0;
    den0 = 1'b1;
    @(negedge clk);
    den0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst do", do0, 16'h0000);
    chk("arst drdy", drdy0, 1'b0);
    chk("arst eoc", eoc0, 1'b0);
    chk("arst busy", busy0, 1'b0);
    chk("arst channel", ch0, 5'h00);
    chk("arst err", err0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (drdy0) pulses++;
    end
    chk("no drdy after arst", pulses, 0);
    drp(1'b0, 1'b0, 7'h41, 16'h0000, 4, 16'h0000, "cfg cleared");
    drp(1'b0, 1'b0, 7'h16, 16'h0000, 4, 16'h0000, "result cleared");

    // Single-cycle latency build
    drp(1'b1, 1'b1, 7'h42, 16'hBEEF, 1, 16'h0000, "L1 wr42");
    drp(1'b1, 1'b0, 7'h42, 16'h0000, 1, 16'hBEEF, "L1 rd42");
    chk("L1 err clear", err1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
